// File: rtl/jtcop_snd_mailbox_if.sv
// Purpose: sound-CPU bus bundle between the 6502 core and the sound mailbox glue.
// Latency: none, plain wires.
// Backpressure: rdy stalls the CPU while a ROM fetch is not yet valid.
// Signals: cpu_addr/cpu_rnw/cpu_dout driven by the CPU; cpu_din/rdy/nmin driven by the glue.
interface jtcop_snd_mailbox_if;
  logic [15:0] cpu_addr;
  logic        cpu_rnw;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        rdy;
  logic        nmin;

  modport master (
    output cpu_addr, cpu_rnw, cpu_dout,
    input  cpu_din, rdy, nmin
  );

  modport slave (
    input  cpu_addr, cpu_rnw, cpu_dout,
    output cpu_din, rdy, nmin
  );
endinterface

// File: rtl/jtcop_snd_mailbox.sv
// Purpose: 6502 sound-board bus glue: address decode, read mux, command FIFO, NMI sequencer, ROM bank.
// Latency: selects/ROM/RAM/FIFO data combinational; opn/opl/oki data 1 clk after select; push 1 clk.
// Backpressure: rdy = ~rom_cs | rom_ok; pushes into a full FIFO are dropped and flag overflow.
// Ports: clk/rst (sync, active high), cen; snreq/latch command input; cpu (bus interface, slave);
//   rom/ram/opn/opl/oki selects and read data, rom_ok; snd_bank; fifo_level; overflow;
//   reply/reply_valid/reply_ack sound-to-main reply path.
// Build option: define JTCOP_SND_REPLY_EN to enable the reply register written at 3000-37FF.
module jtcop_snd_mailbox #(
  parameter int DEPTH  = 4,
  parameter int BANKS  = 0,
  parameter int BANKW  = 1,
  parameter int NMIGAP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     snreq,
  input  logic [7:0]               latch,
  jtcop_snd_mailbox_if.slave       cpu,
  output logic                     rom_cs,
  output logic                     ram_cs,
  output logic                     opn_cs,
  output logic                     opl_cs,
  output logic                     oki_cs,
  input  logic [7:0]               rom_data,
  input  logic [7:0]               ram_dout,
  input  logic [7:0]               opn_dout,
  input  logic [7:0]               opl_dout,
  input  logic [7:0]               oki_dout,
  input  logic                     rom_ok,
  output logic [BANKW-1:0]         snd_bank,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               reply,
  output logic                     reply_valid,
  input  logic                     reply_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (NMIGAP > 2) ? $clog2(NMIGAP) : 1;

  // ---------------- address decode ----------------
  logic mbox_cs, cmd_rd, cmd_wr;

  always_comb begin
    ram_cs  = 1'b0;
    opn_cs  = 1'b0;
    opl_cs  = 1'b0;
    oki_cs  = 1'b0;
    mbox_cs = 1'b0;
    rom_cs  = |cpu.cpu_addr[15:14];
    if (!rom_cs) begin
      case (cpu.cpu_addr[13:11])
        3'd0:    ram_cs  = 1'b1;
        3'd1:    opn_cs  = 1'b1;
        3'd2:    opl_cs  = 1'b1;
        3'd6:    mbox_cs = 1'b1;
        3'd7:    oki_cs  = 1'b1;
        default: ;
      endcase
    end
  end

  assign cmd_rd  = mbox_cs &  cpu.cpu_rnw;
  assign cmd_wr  = mbox_cs & ~cpu.cpu_rnw;
  assign cpu.rdy = ~rom_cs | rom_ok;

  // ---------------- command FIFO ----------------
  // Pointers carry one extra bit so full and empty are told apart by their difference.
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          snreq_l;
  logic [7:0]    last_pop;
  logic          empty, full, push_req, push, pop;
  logic [7:0]    head, mbox_dat;

  assign fifo_level = wr_ptr - rd_ptr;
  assign empty      = (fifo_level == '0);
  assign full       = (fifo_level == LW'(DEPTH));
  assign push_req   = snreq & ~snreq_l;
  assign pop        = cen & cmd_rd & cpu.rdy & ~empty;
  // A pop in the same clk frees the slot, so a push into a full FIFO is still taken then.
  assign push       = push_req & (~full | pop);
  assign head       = mem[rd_ptr[AW-1:0]];
  // Reading an empty mailbox repeats the byte the CPU last consumed.
  assign mbox_dat   = empty ? last_pop : head;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      snreq_l  <= 1'b0;
      overflow <= 1'b0;
      last_pop <= 8'hFF;
    end else begin
      snreq_l <= snreq;
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= latch;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= head;
      end
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // ---------------- read data mux ----------------
  logic [7:0] dev_q;

  always_ff @(posedge clk) begin
    if (rst)         dev_q <= 8'hFF;
    else if (opn_cs) dev_q <= opn_dout;
    else if (opl_cs) dev_q <= opl_dout;
    else if (oki_cs) dev_q <= oki_dout;
    else             dev_q <= 8'hFF;
  end

  always_comb begin
    cpu.cpu_din = 8'hFF;
    if (rom_cs)                        cpu.cpu_din = rom_data;
    else if (ram_cs)                   cpu.cpu_din = ram_dout;
    else if (cmd_rd)                   cpu.cpu_din = mbox_dat;
    else if (opn_cs | opl_cs | oki_cs) cpu.cpu_din = dev_q;
  end

  // ---------------- NMI sequencer ----------------
  // One low NMI period per queued byte, with at least NMIGAP cen high in between
  // so the 6502 sees a fresh falling edge for each command.
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_GAP} nmi_state_t;

  nmi_state_t    st, st_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic          nmin_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      gap_cnt <= '0;
    end else if (cen) begin
      st      <= st_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    gap_nxt = gap_cnt;
    nmin_c  = 1'b1;
    case (st)
      ST_IDLE: if (!empty) st_nxt = ST_PEND;
      ST_PEND: begin
        nmin_c = 1'b0;
        if (pop) begin
          st_nxt  = ST_GAP;
          gap_nxt = GW'(NMIGAP - 1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) st_nxt = empty ? ST_IDLE : ST_PEND;
        else               gap_nxt = gap_cnt - GW'(1);
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  assign cpu.nmin = nmin_c;

  // ---------------- ROM bank register ----------------
  generate
    if (BANKS == 1) begin : g_bank
      always_ff @(posedge clk) begin
        if (rst)
          snd_bank <= '0;
        else if (cen && cpu.cpu_addr[15] && !cpu.cpu_rnw)
          snd_bank <= cpu.cpu_dout[BANKW-1:0];
      end
    end else begin : g_nobank
      assign snd_bank = '0;
    end
  endgenerate

  // ---------------- sound-to-main reply ----------------
`ifdef JTCOP_SND_REPLY_EN
  // A write in the same clk as an ack wins: the new byte is still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      reply       <= 8'hFF;
      reply_valid <= 1'b0;
    end else if (cen && cmd_wr) begin
      reply       <= cpu.cpu_dout;
      reply_valid <= 1'b1;
    end else if (reply_ack) begin
      reply_valid <= 1'b0;
    end
  end
`else
  assign reply       = 8'hFF;
  assign reply_valid = 1'b0;
`endif

  // Address bits below the decode granule and option-dependent inputs are not needed everywhere.
  wire unused_ok = &{1'b0, cpu.cpu_addr[10:0], cpu.cpu_dout, reply_ack, cmd_wr};

endmodule

// File: tb/tb_jtcop_snd_mailbox.sv
module tb_jtcop_snd_mailbox;

  localparam int NMIGAP = 4;

  logic       clk = 1'b0;
  logic       rst, cen, snreq;
  logic [7:0] latch;
  logic       rom_cs, ram_cs, opn_cs, opl_cs, oki_cs;
  logic [7:0] rom_data, ram_dout, opn_dout, opl_dout, oki_dout;
  logic       rom_ok;
  logic [1:0] snd_bank;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [7:0] reply;
  logic       reply_valid, reply_ack;

  int nchk = 0;
  int nerr = 0;

  jtcop_snd_mailbox_if bus ();

  jtcop_snd_mailbox #(
    .DEPTH(4), .BANKS(1), .BANKW(2), .NMIGAP(NMIGAP)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen), .snreq(snreq), .latch(latch), .cpu(bus),
    .rom_cs(rom_cs), .ram_cs(ram_cs), .opn_cs(opn_cs), .opl_cs(opl_cs), .oki_cs(oki_cs),
    .rom_data(rom_data), .ram_dout(ram_dout), .opn_dout(opn_dout),
    .opl_dout(opl_dout), .oki_dout(oki_dout), .rom_ok(rom_ok),
    .snd_bank(snd_bank), .fifo_level(fifo_level), .overflow(overflow),
    .reply(reply), .reply_valid(reply_valid), .reply_ack(reply_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic c);
    cen = c;
    @(posedge clk);
    #1;
    cen = 1'b0;
  endtask

  // One 6502 cycle with the bus parked on an unmapped address.
  task automatic idle_cyc();
    bus.cpu_addr = 16'h2000;
    bus.cpu_rnw  = 1'b1;
    step(1'b0);
    step(1'b1);
  endtask

  task automatic push(input logic [7:0] b);
    latch = b;
    snreq = 1'b1;
    step(1'b0);
    snreq = 1'b0;
    step(1'b0);
  endtask

  // Data is sampled before the cen edge that completes the read.
  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
    bus.cpu_addr = a;
    bus.cpu_rnw  = 1'b1;
    step(1'b0);
    d = bus.cpu_din;
    step(1'b1);
    bus.cpu_addr = 16'h2000;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] v);
    bus.cpu_addr = a;
    bus.cpu_rnw  = 1'b0;
    bus.cpu_dout = v;
    step(1'b0);
    step(1'b1);
    bus.cpu_addr = 16'h2000;
    bus.cpu_rnw  = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    int         n;
    logic [7:0] exp_b;

    rst = 1'b1; cen = 1'b0; snreq = 1'b0; latch = 8'h00;
    rom_data = 8'h00; ram_dout = 8'h00; opn_dout = 8'h5A; opl_dout = 8'h00; oki_dout = 8'h00;
    rom_ok = 1'b1; reply_ack = 1'b0;
    bus.cpu_addr = 16'h0800; bus.cpu_rnw = 1'b1; bus.cpu_dout = 8'h00;

    // Reset state; device mux register must hold FF while in reset even with opn selected.
    step(1'b1); step(1'b1); step(1'b1);
    check("rst_nmin", bus.nmin, 1'b1);
    check("rst_level", fifo_level, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_bank", snd_bank, 2'b00);
    check("rst_devmux", bus.cpu_din, 8'hFF);
    check("rst_reply", reply, 8'hFF);
    check("rst_reply_valid", reply_valid, 1'b0);
    rst = 1'b0;
    bus.cpu_addr = 16'h2000;
    step(1'b0);

    // Single command.
    push(8'h42);
    check("single_level", fifo_level, 3'd1);
    check("single_nmin_idle_no_cen", bus.nmin, 1'b1);
    step(1'b1);
    check("single_nmin_low", bus.nmin, 1'b0);
    cpu_rd(16'h3000, d);
    check("single_data", d, 8'h42);
    check("single_level_after", fifo_level, 3'd0);
    check("single_nmin_rise", bus.nmin, 1'b1);

    // Fill to DEPTH, then overflow.
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("fill_level", fifo_level, 3'd4);
    push(8'h05);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_level", fifo_level, 3'd4);

    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (bus.nmin && n < 20) begin
        idle_cyc();
        n++;
      end
      check($sformatf("burst_nmi_low_%0d", i), bus.nmin, 1'b0);
      cpu_rd(16'h3000, d);
      exp_b = 8'(i + 1);
      check($sformatf("burst_data_%0d", i), d, exp_b);
      if (i < 3) begin
        n = 0;
        do begin
          idle_cyc();
          n++;
        end while (bus.nmin && n < 20);
        check($sformatf("burst_gap_%0d", i), 16'(n), 16'(NMIGAP));
      end
    end
    check("burst_level_empty", fifo_level, 3'd0);
    check("ovf_sticky", overflow, 1'b1);
    cpu_rd(16'h3000, d);
    check("empty_read_last", d, 8'h04);
    check("empty_read_level", fifo_level, 3'd0);

    // Push and pop on the same clk, level 2.
    push(8'hAA);
    push(8'hBB);
    check("pp2_level_before", fifo_level, 3'd2);
    bus.cpu_addr = 16'h3000;
    bus.cpu_rnw  = 1'b1;
    step(1'b0);
    check("pp2_data_head", bus.cpu_din, 8'hAA);
    latch = 8'hCC;
    snreq = 1'b1;
    step(1'b1);
    check("pp2_level_after", fifo_level, 3'd2);
    snreq = 1'b0;
    bus.cpu_addr = 16'h2000;
    step(1'b0);
    cpu_rd(16'h3000, d);
    check("pp2_order_1", d, 8'hBB);
    cpu_rd(16'h3000, d);
    check("pp2_order_2", d, 8'hCC);
    check("pp2_level_end", fifo_level, 3'd0);

    // Push and pop on the same clk while full.
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    check("ppf_level_before", fifo_level, 3'd4);
    bus.cpu_addr = 16'h3000;
    step(1'b0);
    check("ppf_data_head", bus.cpu_din, 8'h10);
    latch = 8'h14;
    snreq = 1'b1;
    step(1'b1);
    check("ppf_level_after", fifo_level, 3'd4);
    snreq = 1'b0;
    bus.cpu_addr = 16'h2000;
    step(1'b0);
    for (int i = 0; i < 4; i++) begin
      cpu_rd(16'h3000, d);
      exp_b = 8'h11 + 8'(i);
      check($sformatf("ppf_order_%0d", i), d, exp_b);
    end

    // Bank register, ROM path, rdy, device mux latency, RAM.
    cpu_wr(16'h8000, 8'h03);
    check("bank_write", snd_bank, 2'b11);
    bus.cpu_addr = 16'hC123;
    rom_data     = 8'h77;
    #1;
    check("rom_read", bus.cpu_din, 8'h77);
    check("rom_cs", rom_cs, 1'b1);
    rom_ok = 1'b0;
    #1;
    check("rdy_rom_wait", bus.rdy, 1'b0);
    rom_ok = 1'b1;
    step(1'b0);
    bus.cpu_addr = 16'h0800;
    #1;
    check("opn_cs", opn_cs, 1'b1);
    check("opn_same_clk", bus.cpu_din, 8'hFF);
    step(1'b0);
    check("opn_next_clk", bus.cpu_din, 8'h5A);
    bus.cpu_addr = 16'h2000;
    #1;
    check("unmapped_read", bus.cpu_din, 8'hFF);
    bus.cpu_addr = 16'h0000;
    ram_dout     = 8'h3C;
    #1;
    check("ram_read", bus.cpu_din, 8'h3C);
    bus.cpu_addr = 16'h2000;
    step(1'b0);

    // Reply path.
    cpu_wr(16'h3000, 8'h99);
`ifdef JTCOP_SND_REPLY_EN
    check("reply_data", reply, 8'h99);
    check("reply_valid_set", reply_valid, 1'b1);
    reply_ack = 1'b1;
    step(1'b0);
    reply_ack = 1'b0;
    check("reply_ack_clear", reply_valid, 1'b0);
    bus.cpu_addr = 16'h3000;
    bus.cpu_rnw  = 1'b0;
    bus.cpu_dout = 8'h55;
    reply_ack    = 1'b1;
    step(1'b1);
    reply_ack    = 1'b0;
    bus.cpu_addr = 16'h2000;
    bus.cpu_rnw  = 1'b1;
    check("reply_wr_ack_data", reply, 8'h55);
    check("reply_wr_ack_valid", reply_valid, 1'b1);
`else
    check("reply_tied", reply, 8'hFF);
    check("reply_valid_tied", reply_valid, 1'b0);
`endif
    check("cmd_wr_no_push", fifo_level, 3'd0);

    // Reset mid-operation.
    repeat (6) idle_cyc();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    check("midrst_level_before", fifo_level, 3'd3);
    step(1'b1);
    check("midrst_nmin_before", bus.nmin, 1'b0);
    rst = 1'b1;
    step(1'b0);
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_nmin", bus.nmin, 1'b1);
    check("midrst_overflow", overflow, 1'b0);
    check("midrst_bank", snd_bank, 2'b00);
    rst = 1'b0;
    step(1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
